rd_return_router: RTL and testbench

Parametrised read-data return path for the bus interconnect: routes each read-data beat from one slave port back to the master that issued the read. It supports N masters and up to DEPTH outstanding reads per slave, and responses return in request order. One instance sits on each slave port, between the slave's read-data bus and the per-master rdata/data_read lanes. Unlike the previous two-master, single-outstanding router, requester identity is queued at command acceptance, so responses no longer depend on live master status.

---
 rtl/rdr_pkg.sv | 27 ++
 rtl/rd_return_router_if.sv | 34 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/rd_return_router.sv | 80 ++++++++
 tb/tb_rd_return_router.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rdr_pkg.sv
// Shared helpers for the read-data return router:
// width derivation and lane slicing.
package rdr_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int mid_w(input int n_masters);
    return (clog2(n_masters) > 32'sd1) ? clog2(n_masters) : 32'sd1;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 32'sd1);
  endfunction

  // Low bit of lane index 'lane' in a flattened per-master data vector.
  function automatic int lane_lo(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/rd_return_router_if.sv
// Signal bundle between one slave port's read path and its return router.
// The router takes the slave modport; whoever drives commands takes master.
interface rd_return_router_if #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
);
  import rdr_pkg::*;

  localparam int MID_W = mid_w(N_MASTERS);
  localparam int CNT_W = cnt_w(DEPTH);

  logic                          req_valid;
  logic [MID_W-1:0]              req_mid;
  logic                          req_ready;
  logic                          rsp_valid;
  logic [DATA_W-1:0]             rdata_in;
  logic [N_MASTERS*DATA_W-1:0]   rdata;
  logic [N_MASTERS-1:0]          data_read;
  logic [CNT_W-1:0]              outstanding;
  logic                          err_orphan;
  logic                          err_bad_mid;

  modport master (
    output req_valid, req_mid, rsp_valid, rdata_in,
    input  req_ready, rdata, data_read, outstanding, err_orphan, err_bad_mid
  );

  modport slave (
    input  req_valid, req_mid, rsp_valid, rdata_in,
    output req_ready, rdata, data_read, outstanding, err_orphan, err_bad_mid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop is judged against the
// occupancy before this cycle's push, so an empty FIFO never forwards a same-cycle write.
module sync_fifo import rdr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_w(DEPTH)-1:0]     count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rd_return_router.sv
// Read-data return router: queues the requester ID when a read command is accepted
// and steers each response beat, in order, onto that master's rdata lane.
module rd_return_router import rdr_pkg::*; #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               reset,
  rd_return_router_if.slave  bus
);

  localparam int MID_W = mid_w(N_MASTERS);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [N_MASTERS*DATA_W-1:0] rdata_q, rdata_d;
  logic [N_MASTERS-1:0]        data_read_q, data_read_d;
  logic                        err_orphan_q, err_orphan_d;
  logic                        err_bad_mid_q, err_bad_mid_d;
  logic [MID_W-1:0]            head_mid_s;
  logic [CNT_W-1:0]            count_s;
  logic                        full_s, empty_s, mid_ok_s, push_s, pop_s;

  // One extra bit so the compare also covers N_MASTERS equal to 2**MID_W.
  assign mid_ok_s = ({1'b0, bus.req_mid} < (MID_W+1)'(N_MASTERS));
  assign push_s   = bus.req_valid && !full_s && mid_ok_s;
  assign pop_s    = bus.rsp_valid && !empty_s;

  sync_fifo #(
    .WIDTH (MID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (bus.req_mid),
    .pop   (pop_s),
    .rdata (head_mid_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign bus.req_ready   = !full_s;
  assign bus.outstanding = count_s;
  assign bus.rdata       = rdata_q;
  assign bus.data_read   = data_read_q;
  assign bus.err_orphan  = err_orphan_q;
  assign bus.err_bad_mid = err_bad_mid_q;

  always_comb begin
    rdata_d     = {(N_MASTERS*DATA_W){1'b0}};
    data_read_d = {N_MASTERS{1'b0}};
    for (int m = 0; m < N_MASTERS; m++) begin
      if (pop_s && (head_mid_s == MID_W'(m))) begin
        rdata_d[lane_lo(m, DATA_W) +: DATA_W] = bus.rdata_in;
        data_read_d[m]                        = 1'b1;
      end else begin
        data_read_d[m] = 1'b0;
      end
    end
    err_orphan_d  = err_orphan_q  || (bus.rsp_valid && empty_s);
    err_bad_mid_d = err_bad_mid_q || (bus.req_valid && !full_s && !mid_ok_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q       <= {(N_MASTERS*DATA_W){1'b0}};
      data_read_q   <= {N_MASTERS{1'b0}};
      err_orphan_q  <= 1'b0;
      err_bad_mid_q <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      data_read_q   <= data_read_d;
      err_orphan_q  <= err_orphan_d;
      err_bad_mid_q <= err_bad_mid_d;
    end
  end

endmodule

// File: tb/tb_rd_return_router.sv
// Directed self-checking bench: a 4-master instance for ordering/full/steady/wrap
// and a 5-master instance for the out-of-range master index and the top lane.
module tb_rd_return_router;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rd_return_router_if #(.N_MASTERS(4), .DATA_W(DW), .DEPTH(4)) b4 ();
  rd_return_router_if #(.N_MASTERS(5), .DATA_W(DW), .DEPTH(4)) b5 ();

  rd_return_router #(.N_MASTERS(4), .DATA_W(DW), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4)
  );
  rd_return_router #(.N_MASTERS(5), .DATA_W(DW), .DEPTH(4)) dut5 (
    .clk(clk), .reset(reset), .bus(b5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b4.req_valid = 1'b0; b4.req_mid = 2'd0; b4.rsp_valid = 1'b0; b4.rdata_in = 32'h0;
    b5.req_valid = 1'b0; b5.req_mid = 3'd0; b5.rsp_valid = 1'b0; b5.rdata_in = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    b4.req_valid = 1'b1; b4.req_mid = 2'd1; tick();
    b4.req_mid = 2'd2; tick();
    b4.req_valid = 1'b0;
    n_tests++; if (b4.outstanding !== 3'd2) begin n_fail++; $display("FAIL reset_pre_outstanding: got %0d exp 2", b4.outstanding); end
    reset = 1'b1; b4.rsp_valid = 1'b1; b4.rdata_in = 32'h55; tick(); tick();
    reset = 1'b0; b4.rsp_valid = 1'b0;
    n_tests++; if (b4.rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", b4.rdata); end
    n_tests++; if (b4.data_read !== 4'b0000) begin n_fail++; $display("FAIL reset_data_read: got %b exp 0000", b4.data_read); end
    n_tests++; if (b4.outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", b4.outstanding); end
    n_tests++; if (b4.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", b4.req_ready); end
    n_tests++; if (b4.err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err_orphan: got %b exp 0", b4.err_orphan); end
    n_tests++; if (b5.err_bad_mid !== 1'b0) begin n_fail++; $display("FAIL reset_err_bad_mid: got %b exp 0", b5.err_bad_mid); end
    // Response for a request that was in flight before reset is an orphan.
    b4.rsp_valid = 1'b1; b4.rdata_in = 32'h77; tick();
    b4.rsp_valid = 1'b0;
    n_tests++; if (b4.data_read !== 4'b0000) begin n_fail++; $display("FAIL reset_orphan_strobe: got %b exp 0000", b4.data_read); end
    n_tests++; if (b4.rdata !== 128'h0) begin n_fail++; $display("FAIL reset_orphan_rdata: got %h exp 0", b4.rdata); end
    n_tests++; if (b4.err_orphan !== 1'b1) begin n_fail++; $display("FAIL reset_orphan_flag: got %b exp 1", b4.err_orphan); end
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests++; if (b4.err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_clears_orphan: got %b exp 0", b4.err_orphan); end
  endtask

  task automatic test_ordering();
    logic [3:0]   exp_dr [3];
    logic [31:0]  exp_d  [3];
    int           exp_l  [3];
    logic [127:0] exp_rd;
    exp_dr[0] = 4'b0100; exp_dr[1] = 4'b0001; exp_dr[2] = 4'b1000;
    exp_d[0]  = 32'hA;   exp_d[1]  = 32'hB;   exp_d[2]  = 32'hC;
    exp_l[0]  = 2;       exp_l[1]  = 0;       exp_l[2]  = 3;
    b4.req_valid = 1'b1;
    b4.req_mid = 2'd2; tick();
    b4.req_mid = 2'd0; tick();
    b4.req_mid = 2'd3; tick();
    b4.req_valid = 1'b0;
    b4.rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b4.rdata_in = exp_d[i];
      tick();
      exp_rd = 128'h0;
      exp_rd[exp_l[i]*DW +: DW] = exp_d[i];
      n_tests++; if (b4.data_read !== exp_dr[i]) begin n_fail++; $display("FAIL order_strobe[%0d]: got %b exp %b", i, b4.data_read, exp_dr[i]); end
      n_tests++; if (b4.rdata !== exp_rd) begin n_fail++; $display("FAIL order_rdata[%0d]: got %h exp %h", i, b4.rdata, exp_rd); end
    end
    b4.rsp_valid = 1'b0;
    tick();
    n_tests++; if (b4.data_read !== 4'b0000) begin n_fail++; $display("FAIL order_idle_strobe: got %b exp 0000", b4.data_read); end
    n_tests++; if (b4.rdata !== 128'h0) begin n_fail++; $display("FAIL order_idle_rdata: got %h exp 0", b4.rdata); end
    n_tests++; if (b4.outstanding !== 3'd0) begin n_fail++; $display("FAIL order_outstanding: got %0d exp 0", b4.outstanding); end
  endtask

  task automatic test_full();
    logic [127:0] exp_rd;
    b4.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.req_mid = 2'(i);
      tick();
      if (i == 2) begin
        n_tests++; if (b4.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_at3: got %b exp 1", b4.req_ready); end
      end
    end
    n_tests++; if (b4.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_at4: got %b exp 0", b4.req_ready); end
    n_tests++; if (b4.outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding: got %0d exp 4", b4.outstanding); end
    b4.req_mid = 2'd1; tick();
    n_tests++; if (b4.outstanding !== 3'd4) begin n_fail++; $display("FAIL full_drop_outstanding: got %0d exp 4", b4.outstanding); end
    // Push refused while full; the pop still drains the head (master 0).
    b4.req_mid = 2'd2; b4.rsp_valid = 1'b1; b4.rdata_in = 32'h100; tick();
    b4.req_valid = 1'b0;
    n_tests++; if (b4.outstanding !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_outstanding: got %0d exp 3", b4.outstanding); end
    n_tests++; if (b4.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b exp 1", b4.req_ready); end
    n_tests++; if (b4.data_read !== 4'b0001) begin n_fail++; $display("FAIL full_pushpop_strobe: got %b exp 0001", b4.data_read); end
    for (int i = 1; i < 4; i++) begin
      b4.rdata_in = 32'h100 + 32'(i);
      tick();
      exp_rd = 128'h0;
      exp_rd[i*DW +: DW] = 32'h100 + 32'(i);
      n_tests++; if (b4.rdata !== exp_rd) begin n_fail++; $display("FAIL full_drain_rdata[%0d]: got %h exp %h", i, b4.rdata, exp_rd); end
    end
    b4.rsp_valid = 1'b0;
    tick();
    n_tests++; if (b4.outstanding !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d exp 0", b4.outstanding); end
  endtask

  task automatic test_steady();
    int           q[$];
    int           lane;
    logic [3:0]   exp_dr;
    logic [127:0] exp_rd;
    b4.req_valid = 1'b1;
    b4.req_mid = 2'd1; tick(); q.push_back(1);
    b4.req_mid = 2'd3; tick(); q.push_back(3);
    b4.rsp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b4.req_mid  = 2'(i % 4);
      b4.rdata_in = 32'h200 + 32'(i);
      tick();
      lane = q.pop_front();
      q.push_back(i % 4);
      exp_dr = 4'b0001 << lane;
      exp_rd = 128'h0;
      exp_rd[lane*DW +: DW] = 32'h200 + 32'(i);
      n_tests++; if (b4.data_read !== exp_dr) begin n_fail++; $display("FAIL steady_strobe[%0d]: got %b exp %b", i, b4.data_read, exp_dr); end
      n_tests++; if (b4.rdata !== exp_rd) begin n_fail++; $display("FAIL steady_rdata[%0d]: got %h exp %h", i, b4.rdata, exp_rd); end
      n_tests++; if (b4.outstanding !== 3'd2) begin n_fail++; $display("FAIL steady_outstanding[%0d]: got %0d exp 2", i, b4.outstanding); end
    end
    b4.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b4.rdata_in = 32'h300 + 32'(i);
      tick();
      lane = q.pop_front();
      exp_dr = 4'b0001 << lane;
      n_tests++; if (b4.data_read !== exp_dr) begin n_fail++; $display("FAIL steady_drain[%0d]: got %b exp %b", i, b4.data_read, exp_dr); end
    end
    b4.rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    logic [159:0] exp_rd5;
    b5.req_valid = 1'b1; b5.req_mid = 3'd5; tick();
    b5.req_valid = 1'b0;
    n_tests++; if (b5.err_bad_mid !== 1'b1) begin n_fail++; $display("FAIL err_bad_mid_set: got %b exp 1", b5.err_bad_mid); end
    n_tests++; if (b5.outstanding !== 3'd0) begin n_fail++; $display("FAIL err_bad_mid_outstanding: got %0d exp 0", b5.outstanding); end
    // Highest legal index goes to the top lane.
    b5.req_valid = 1'b1; b5.req_mid = 3'd4; tick();
    b5.req_valid = 1'b0; b5.rsp_valid = 1'b1; b5.rdata_in = 32'hDEAD; tick();
    b5.rsp_valid = 1'b0;
    exp_rd5 = 160'h0;
    exp_rd5[4*DW +: DW] = 32'hDEAD;
    n_tests++; if (b5.data_read !== 5'b10000) begin n_fail++; $display("FAIL top_lane_strobe: got %b exp 10000", b5.data_read); end
    n_tests++; if (b5.rdata !== exp_rd5) begin n_fail++; $display("FAIL top_lane_rdata: got %h exp %h", b5.rdata, exp_rd5); end
    n_tests++; if (b5.err_orphan !== 1'b0) begin n_fail++; $display("FAIL err_orphan_early: got %b exp 0", b5.err_orphan); end
    b5.rsp_valid = 1'b1; b5.rdata_in = 32'hBEEF; tick();
    b5.rsp_valid = 1'b0;
    n_tests++; if (b5.err_orphan !== 1'b1) begin n_fail++; $display("FAIL err_orphan_set: got %b exp 1", b5.err_orphan); end
    n_tests++; if (b5.data_read !== 5'b00000) begin n_fail++; $display("FAIL err_orphan_strobe: got %b exp 00000", b5.data_read); end
    tick(); tick(); tick();
    n_tests++; if (b5.err_orphan !== 1'b1) begin n_fail++; $display("FAIL err_orphan_sticky: got %b exp 1", b5.err_orphan); end
    n_tests++; if (b5.err_bad_mid !== 1'b1) begin n_fail++; $display("FAIL err_bad_mid_sticky: got %b exp 1", b5.err_bad_mid); end
    // Orphan response alongside a push: push queues, response is not matched to it.
    b4.req_valid = 1'b1; b4.req_mid = 2'd3; b4.rsp_valid = 1'b1; b4.rdata_in = 32'hBAD; tick();
    b4.req_valid = 1'b0;
    n_tests++; if (b4.err_orphan !== 1'b1) begin n_fail++; $display("FAIL same_cycle_orphan: got %b exp 1", b4.err_orphan); end
    n_tests++; if (b4.data_read !== 4'b0000) begin n_fail++; $display("FAIL same_cycle_strobe: got %b exp 0000", b4.data_read); end
    n_tests++; if (b4.outstanding !== 3'd1) begin n_fail++; $display("FAIL same_cycle_outstanding: got %0d exp 1", b4.outstanding); end
    b4.rdata_in = 32'hC0; tick();
    b4.rsp_valid = 1'b0;
    n_tests++; if (b4.data_read !== 4'b1000) begin n_fail++; $display("FAIL same_cycle_match: got %b exp 1000", b4.data_read); end
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests++; if (b5.err_orphan !== 1'b0) begin n_fail++; $display("FAIL err_orphan_cleared: got %b exp 0", b5.err_orphan); end
    n_tests++; if (b5.err_bad_mid !== 1'b0) begin n_fail++; $display("FAIL err_bad_mid_cleared: got %b exp 0", b5.err_bad_mid); end
  endtask

  task automatic test_wrap();
    int           q[$];
    int           pushed = 0;
    int           popped = 0;
    int           lane;
    int           mid = 0;
    bit           do_push, do_pop;
    logic [31:0]  d;
    logic [3:0]   exp_dr;
    logic [127:0] exp_rd;
    for (int c = 0; c < 14; c++) begin
      do_push = (pushed < 12);
      do_pop  = (c >= 2) && (popped < 12);
      b4.req_valid = do_push;
      if (do_push) begin
        mid = int'($urandom_range(0, 3));
        b4.req_mid = 2'(mid);
      end
      d = $urandom;
      b4.rsp_valid = do_pop;
      b4.rdata_in  = d;
      tick();
      exp_dr = 4'b0000;
      exp_rd = 128'h0;
      if (do_pop) begin
        lane = q.pop_front();
        exp_dr = 4'b0001 << lane;
        exp_rd[lane*DW +: DW] = d;
        popped++;
      end
      if (do_push) begin
        q.push_back(mid);
        pushed++;
      end
      n_tests++; if (b4.data_read !== exp_dr) begin n_fail++; $display("FAIL wrap_strobe[%0d]: got %b exp %b", c, b4.data_read, exp_dr); end
      n_tests++; if (b4.rdata !== exp_rd) begin n_fail++; $display("FAIL wrap_rdata[%0d]: got %h exp %h", c, b4.rdata, exp_rd); end
    end
    idle();
    tick();
    n_tests++; if (b4.outstanding !== 3'd0) begin n_fail++; $display("FAIL wrap_outstanding: got %0d exp 0", b4.outstanding); end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full();
    test_steady();
    test_errors();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
